// File: rtl/remodel_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NumReq requesters.
// Read responses are routed back to the issuing requester through a Latency-deep id pipeline.
module remodel_sram_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic [NumReq-1:0]                req_we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0] req_addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0] req_wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]   req_be_i,
  output logic [NumReq-1:0]                rsp_valid_o,
  output logic [DataWidth-1:0]             rsp_rdata_o,
  output logic                             sram_req_o,
  output logic                             sram_we_o,
  output logic [AddrWidth-1:0]             sram_addr_o,
  output logic [DataWidth-1:0]             sram_wdata_o,
  output logic [BeWidth-1:0]               sram_be_o,
  input  logic [DataWidth-1:0]             sram_rdata_i
);

  localparam int unsigned IdWidth  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned SumWidth = IdWidth + 1;
  localparam logic [SumWidth-1:0] NumReqS = SumWidth'(NumReq);

  logic [IdWidth-1:0]  rr_q;
  logic [IdWidth-1:0]  rr_d;
  logic                gnt_any;
  logic [IdWidth-1:0]  gnt_idx;
  logic [SumWidth-1:0] cand;
  logic [SumWidth-1:0] gnt_inc;
  logic                rd_acc;
  logic                rsp_vld;
  logic [IdWidth-1:0]  rsp_id;

  // Circular scan from rr_q; the first valid requester wins. Reset blocks every grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int off = 0; off < int'(NumReq); off++) begin
      cand = SumWidth'(rr_q) + SumWidth'(off);
      if (cand >= NumReqS) begin
        cand = cand - NumReqS;
      end
      if (!gnt_any && !rst_i && req_valid_i[IdWidth'(cand)]) begin
        gnt_any = 1'b1;
        gnt_idx = IdWidth'(cand);
      end
    end
  end

  // Pointer moves just past the winner; it holds while idle.
  always_comb begin
    gnt_inc = SumWidth'(gnt_idx) + SumWidth'(1);
    if (gnt_inc >= NumReqS) begin
      gnt_inc = '0;
    end
    rr_d = gnt_any ? IdWidth'(gnt_inc) : rr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  // SRAM command mux; everything is zero when nobody is granted.
  always_comb begin
    req_ready_o  = '0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (gnt_any) begin
      req_ready_o[gnt_idx] = 1'b1;
      sram_req_o           = 1'b1;
      sram_we_o            = req_we_i[gnt_idx];
      sram_addr_o          = req_addr_i[gnt_idx];
      sram_wdata_o         = req_wdata_i[gnt_idx];
      sram_be_o            = req_be_i[gnt_idx];
    end
  end

  assign rd_acc = gnt_any && !req_we_i[gnt_idx];

  if (Latency == 0) begin : g_lat0
    assign rsp_vld = rd_acc;
    assign rsp_id  = gnt_idx;
  end else begin : g_pipe
    logic [Latency-1:0]              pipe_vld_q;
    logic [Latency-1:0][IdWidth-1:0] pipe_id_q;

    // Writes enter with valid=0 so the slot timing stays aligned with the SRAM.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pipe_vld_q <= '0;
        pipe_id_q  <= '0;
      end else begin
        pipe_vld_q <= Latency'({pipe_vld_q, rd_acc});
        pipe_id_q  <= (Latency * IdWidth)'({pipe_id_q, gnt_idx});
      end
    end

    assign rsp_vld = pipe_vld_q[Latency-1];
    assign rsp_id  = pipe_id_q[Latency-1];
  end

  // Shared read data is steered to one requester and zeroed otherwise.
  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    if (rsp_vld && !rst_i) begin
      rsp_valid_o[rsp_id] = 1'b1;
      rsp_rdata_o         = sram_rdata_i;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(req_ready_o));
  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rsp_valid_o));

endmodule

// File: tb/tb_remodel_sram_arbiter.sv
// Bench for remodel_sram_arbiter: three instances (Latency 0, 1, 2) share stimulus and are
// compared every cycle against a queue-based reference model, plus literal directed checks.
module tb_remodel_sram_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned NL = 3;
  localparam int unsigned MD = 1024;

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]         req_valid;
  logic [NR-1:0]         req_we;
  logic [NR-1:0][AW-1:0] req_addr;
  logic [NR-1:0][DW-1:0] req_wdata;
  logic [NR-1:0][BW-1:0] req_be;

  logic [NR-1:0] ready      [NL];
  logic [NR-1:0] rsp_valid  [NL];
  logic [DW-1:0] rsp_rdata  [NL];
  logic          sram_req   [NL];
  logic          sram_we    [NL];
  logic [AW-1:0] sram_addr  [NL];
  logic [DW-1:0] sram_wdata [NL];
  logic [BW-1:0] sram_be    [NL];
  logic [DW-1:0] sram_rdata [NL];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  int            m_rr;
  logic [DW-1:0] m_mem [MD];
  rsp_t          pend [NL][$];

  logic [NR-1:0] rr_order [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [NR-1:0] l2_order [3] = '{4'b0010, 4'b1000, 4'b0010};

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int a);
    return (DW'(a) * 32'h0101_0101) ^ 32'hC3A5_0000;
  endfunction

  // One instance per latency, each with its own behavioural SRAM.
  for (genvar g = 0; g < int'(NL); g++) begin : g_dut
    remodel_sram_arbiter #(
      .NumReq   (NR),
      .AddrWidth(AW),
      .DataWidth(DW),
      .ByteWidth(8),
      .Latency  (g)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (ready[g]),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_be_i    (req_be),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_rdata_o (rsp_rdata[g]),
      .sram_req_o  (sram_req[g]),
      .sram_we_o   (sram_we[g]),
      .sram_addr_o (sram_addr[g]),
      .sram_wdata_o(sram_wdata[g]),
      .sram_be_o   (sram_be[g]),
      .sram_rdata_i(sram_rdata[g])
    );

    logic [DW-1:0] mem [MD];
    logic [DW-1:0] junk;

    initial begin
      for (int i = 0; i < int'(MD); i++) mem[i] = pat(i);
      junk = 32'h1234_5678;
    end

    always @(posedge clk) begin
      junk <= $urandom;
      if (sram_req[g] && sram_we[g]) begin
        for (int b = 0; b < int'(BW); b++) begin
          if (sram_be[g][b]) mem[sram_addr[g]][8*b +: 8] <= sram_wdata[g][8*b +: 8];
        end
      end
    end

    if (g == 0) begin : g_comb
      assign sram_rdata[g] = (sram_req[g] && !sram_we[g]) ? mem[sram_addr[g]] : junk;
    end else begin : g_seq
      logic [DW-1:0] rd_pipe [g];
      always @(posedge clk) begin
        rd_pipe[0] <= (sram_req[g] && !sram_we[g]) ? mem[sram_addr[g]] : $urandom;
        for (int i = 1; i < g; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
      assign sram_rdata[g] = rd_pipe[g-1];
    end
  end

  task automatic chk(input string nm, input int l, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s lat=%0d cyc=%0d actual=%0h required=%0h", nm, l, cyc, act, exp);
  endtask

  // Reference model: every cycle, derive grant and responses from the arbitration rules.
  always @(negedge clk) begin : cmp
    int            g;
    int            idx;
    rsp_t          r;
    logic [NR-1:0] e_rdy;
    logic          e_req;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [BW-1:0] e_be;
    logic [NR-1:0] e_rv;
    logic [DW-1:0] e_rd;

    g = -1;
    e_rdy = '0; e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
    if (rst) begin
      m_rr = 0;
      for (int l = 0; l < int'(NL); l++) pend[l].delete();
    end else begin
      for (int k = 0; k < int'(NR); k++) begin
        idx = (m_rr + k) % NR;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      if (g >= 0) begin
        e_rdy[g] = 1'b1;
        e_req    = 1'b1;
        e_we     = req_we[g];
        e_addr   = req_addr[g];
        e_wdata  = req_wdata[g];
        e_be     = req_be[g];
        m_rr     = (g + 1) % NR;
        if (req_we[g]) begin
          for (int b = 0; b < int'(BW); b++)
            if (req_be[g][b]) m_mem[req_addr[g]][8*b +: 8] = req_wdata[g][8*b +: 8];
        end else begin
          for (int l = 0; l < int'(NL); l++) begin
            r.due  = cyc + l;
            r.id   = g;
            r.data = m_mem[req_addr[g]];
            pend[l].push_back(r);
          end
        end
      end
    end
    for (int l = 0; l < int'(NL); l++) begin
      e_rv = '0;
      e_rd = '0;
      if (pend[l].size() > 0 && pend[l][0].due == cyc) begin
        r = pend[l].pop_front();
        e_rv[r.id] = 1'b1;
        e_rd = r.data;
      end
      chk("ready", l, 64'(ready[l]), 64'(e_rdy));
      chk("sram_req", l, 64'(sram_req[l]), 64'(e_req));
      chk("sram_we", l, 64'(sram_we[l]), 64'(e_we));
      chk("sram_addr", l, 64'(sram_addr[l]), 64'(e_addr));
      chk("sram_wdata", l, 64'(sram_wdata[l]), 64'(e_wdata));
      chk("sram_be", l, 64'(sram_be[l]), 64'(e_be));
      chk("rsp_valid", l, 64'(rsp_valid[l]), 64'(e_rv));
      chk("rsp_rdata", l, 64'(rsp_rdata[l]), 64'(e_rd));
    end
    cyc++;
  end

  task automatic clr_in();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < int'(MD); i++) m_mem[i] = pat(i);
    m_rr = 0;
    rst  = 1'b1;
    clr_in();
    req_valid = '1;
    for (int i = 0; i < int'(NR); i++) req_addr[i] = AW'(i + 1);

    // Reset forces outputs low even with every requester valid.
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", -1, 64'(ready[1]), 64'h0);
      chk("rst_sram_req", -1, 64'(sram_req[1]), 64'h0);
      chk("rst_rsp", -1, 64'(rsp_valid[2]), 64'h0);
    end

    next(); rst = 1'b0; clr_in();
    @(negedge clk);
    chk("idle_sram_req", -1, 64'(sram_req[1]), 64'h0);
    chk("idle_ready", -1, 64'(ready[1]), 64'h0);
    next();
    @(negedge clk);
    chk("idle_addr", -1, 64'(sram_addr[1]), 64'h0);

    // Single read from requester 1, address 3.
    next(); req_valid = 4'b0010; req_addr[1] = 10'h3;
    @(negedge clk);
    chk("rd_ready", -1, 64'(ready[1]), 64'h2);
    chk("rd_addr", -1, 64'(sram_addr[1]), 64'h3);
    chk("rd_l0_rsp", -1, 64'(rsp_valid[0]), 64'h2);
    chk("rd_l0_data", -1, 64'(rsp_rdata[0]), 64'hC0A6_0303);
    next(); clr_in();
    @(negedge clk);
    chk("rd_l1_rsp", -1, 64'(rsp_valid[1]), 64'h2);
    chk("rd_l1_data", -1, 64'(rsp_rdata[1]), 64'hC0A6_0303);
    next();
    @(negedge clk);
    chk("rd_l2_rsp", -1, 64'(rsp_valid[2]), 64'h2);
    chk("rd_l1_done", -1, 64'(rsp_valid[1]), 64'h0);
    chk("rd_l1_zero", -1, 64'(rsp_rdata[1]), 64'h0);

    // Pointer sits at 2 after idle cycles.
    next();
    @(negedge clk);
    next(); req_valid = '1;
    @(negedge clk);
    chk("rr_hold_idle", -1, 64'(ready[1]), 64'h4);

    next(); clr_in(); rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      next();
      rst = 1'b0;
      req_valid = '1;
      for (int i = 0; i < int'(NR); i++) req_addr[i] = AW'(i + 4);
      @(negedge clk);
      chk("rr_order", -1, 64'(ready[1]), 64'(rr_order[k]));
    end
    repeat (3) begin
      next(); clr_in();
      @(negedge clk);
    end

    // Write 0xAA to 0x10 from requester 0, then read it back from requester 2.
    next(); req_valid = 4'b0001; req_we[0] = 1'b1; req_addr[0] = 10'h10;
    req_wdata[0] = 32'hAA; req_be[0] = 4'hF;
    @(negedge clk);
    chk("wr_ready", -1, 64'(ready[1]), 64'h1);
    chk("wr_we", -1, 64'(sram_we[1]), 64'h1);
    next(); clr_in(); req_valid = 4'b0100; req_addr[2] = 10'h10;
    @(negedge clk);
    chk("wr_no_rsp", -1, 64'(rsp_valid[1]), 64'h0);
    chk("raw_ready", -1, 64'(ready[1]), 64'h4);
    chk("raw_l0_data", -1, 64'(rsp_rdata[0]), 64'hAA);
    next(); clr_in();
    @(negedge clk);
    chk("raw_rsp", -1, 64'(rsp_valid[1]), 64'h4);
    chk("raw_data", -1, 64'(rsp_rdata[1]), 64'hAA);
    next();
    @(negedge clk);

    // Back-to-back reads 1,3,1 on the Latency=2 instance.
    for (int k = 0; k < 5; k++) begin
      next(); clr_in();
      if (k == 0 || k == 2) begin req_valid[1] = 1'b1; req_addr[1] = AW'(32 + k); end
      if (k == 1) begin req_valid[3] = 1'b1; req_addr[3] = AW'(32 + k); end
      @(negedge clk);
      if (k >= 2) chk("l2_b2b", -1, 64'(rsp_valid[2]), 64'(l2_order[k-2]));
    end
    next(); clr_in();
    @(negedge clk);

    // Reset one cycle after a Latency=2 read is accepted.
    next(); req_valid = 4'b0100; req_addr[2] = 10'h5;
    @(negedge clk);
    chk("mid_acc", -1, 64'(ready[2]), 64'h4);
    next(); rst = 1'b1; req_valid = '1;
    @(negedge clk);
    chk("mid_rst_ready", -1, 64'(ready[2]), 64'h0);
    chk("mid_rst_req", -1, 64'(sram_req[2]), 64'h0);
    next(); rst = 1'b0; clr_in(); req_valid = 4'b1010; req_we = 4'b1010;
    req_wdata[1] = 32'h5555_0001; req_be[1] = 4'hF;
    @(negedge clk);
    chk("post_rst_grant", -1, 64'(ready[2]), 64'h2);
    chk("post_rst_rsp", -1, 64'(rsp_valid[2]), 64'h0);
    repeat (3) begin
      next(); clr_in();
      @(negedge clk);
      chk("post_rst_quiet", -1, 64'(rsp_valid[2]), 64'h0);
    end

    // Random traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      next();
      rst       = ($urandom_range(0, 199) == 0);
      req_valid = NR'($urandom);
      req_we    = NR'($urandom);
      for (int i = 0; i < int'(NR); i++) begin
        req_addr[i]  = AW'($urandom_range(0, 15));
        req_wdata[i] = $urandom;
        req_be[i]    = BW'($urandom);
      end
      @(negedge clk);
    end
    next(); rst = 1'b0; clr_in();
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
